tc_seq_ctrl: RTL
================

# tc_seq_ctrl

Sequencer for the tensor-core datapath. It runs one tile job per `start`: a load phase that drives `load_en`, then a compute phase that drives `compute_en` and walks the N/K iteration space (k inner, n outer), then a drain phase that waits out the datapath pipeline. It sits between the host/command interface and `tc_core` and marks, per output column, when the accumulated result is valid. All outputs are registered (Moore).

## Interface
Parameters:
- `ITER_N`, default 16: output-column iterations per job.
- `ITER_K`, default 2: K-slice iterations per column; must be ≥ 1.
- `LOAD_CYC`, default 2: load phase length in cycles; must be ≥ 1.
- `PIPE_LAT`, default 2: cycles from the last compute cycle of a column to its result at `out`; must be ≥ 1.
- `DW_N`, default 4: width of n indices; 2^DW_N ≥ ITER_N.
- `DW_K`, default 1: width of `k_idx`; 2^DW_K ≥ ITER_K.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  job request; sampled only while `ready`=1.
- `abort`  in  1  synchronous cancel of the running job.
- `ready`  out  1  idle; able to accept `start`.
- `busy`  out  1  equals not `ready`.
- `load_en`  out  1  drives `tc_core.load_en`.
- `compute_en`  out  1  drives `tc_core.compute_en`.
- `n_idx`  out  DW_N  current column iteration during compute.
- `k_idx`  out  DW_K  current K-slice during compute.
- `acc_clr`  out  1  first K-slice of a column (`compute_en` && `k_idx`==0).
- `out_valid`  out  1  one-cycle pulse; `tc_core.out` holds column `out_col`.
- `out_col`  out  DW_N  column index qualifying `out_valid`.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, LOAD, COMP, DRAIN.
- IDLE: `ready`=1; all enables 0; counters 0. `start`=1 with `abort`=0 moves to LOAD.
- LOAD: `load_en`=1 for exactly LOAD_CYC cycles, counted by a load counter; then COMP.
- COMP: `compute_en`=1 for ITER_N*ITER_K cycles.
  - `k_idx` increments every cycle and wraps from ITER_K-1 to 0.
  - `n_idx` increments when `k_idx` wraps.
  - After the cycle with n=ITER_N-1 and k=ITER_K-1, the FSM moves to DRAIN; `n_idx`/`k_idx` return to 0.
- Column completion: a COMP cycle with k=ITER_K-1 pushes (valid=1, col=`n_idx`) into a PIPE_LAT-deep shift register. Its output drives `out_valid`/`out_col`. `out_col` holds its last value when `out_valid`=0.
- DRAIN: lasts PIPE_LAT cycles. `done` is asserted in the last DRAIN cycle, coinciding with the final `out_valid` (col ITER_N-1). The FSM then returns to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `abort`=1 in LOAD, COMP or DRAIN:
  - Next cycle is IDLE with all enables 0.
  - The shift register is flushed, so no further `out_valid`.
  - No `done` is generated.
- `abort` in IDLE: no effect. `start` and `abort` together in IDLE: abort wins and the job is not started.
- Reset (asynchronous, any state): IDLE; `ready`=1, `busy`=0; every other output 0; shift register cleared. A job in flight is discarded.

## Timing
- Let `start` be sampled at edge 0.
  - `load_en`=1 in cycles 1..LOAD_CYC.
  - `compute_en`=1 in cycles LOAD_CYC+1..LOAD_CYC+ITER_N*ITER_K.
  - `done` in cycle LOAD_CYC+ITER_N*ITER_K+PIPE_LAT.
  - `ready`=1 from the following cycle.
  - Defaults: load 1–2, compute 3–34, done 36, ready 37.
- `load_en` and `compute_en` are never high in the same cycle. There is no gap cycle between LOAD and COMP.
- Column n's `out_valid` occurs PIPE_LAT cycles after its k=ITER_K-1 compute cycle. It recurs every ITER_K cycles; with defaults, cycles 6, 8, …, 36.
- ITER_K=1: `acc_clr` is high on every compute cycle, and `out_valid` is high on consecutive cycles.
- Back-to-back jobs: a `start` held high through `done` is accepted in the first `ready` cycle. The minimum gap between jobs is 1 idle cycle.

## Test plan
- Reset during IDLE then release, defaults → `ready`=1 and all other outputs 0. `start` pulse at edge 0 → `load_en` in cycles 1–2, `compute_en` in 3–34, `done` only at 36, `ready` at 37.
- Defaults, check the compute sequence → (n,k) = (0,0),(0,1),(1,0)…(15,1). `acc_clr` on even compute cycles. 16 `out_valid` pulses at cycles 6,8,…,36 with `out_col`=0..15.
- `abort` at cycle 10 (COMP, n=3, k=1) → IDLE at 11, `compute_en`=0. No `out_valid` after cycle 11, no `done`. Then `start` → a full normal job.
- `start` re-pulsed at cycle 5 while busy → ignored; timing identical to scenario 1. `start`+`abort` together in IDLE → stays IDLE.
- ITER_N=4, ITER_K=1, LOAD_CYC=1, PIPE_LAT=3 → load in cycle 1, compute in 2–5, `out_valid` in 5–8 with cols 0–3, `done` at 8.
- `reset` asserted asynchronously mid-DRAIN (cycle 35) → outputs clear immediately, no `done`. After release, `ready`=1.

Source files
------------

// File: rtl/tc_seq_ctrl_if.sv
// Command/status bundle between the host-side command logic and the tile-job sequencer.
// The sequencer uses the slave modport; whoever issues jobs uses the master modport.
interface tc_seq_ctrl_if #(
    parameter int DW_N = 4,
    parameter int DW_K = 1
) ();
    logic            start;
    logic            abort;
    logic            ready;
    logic            busy;
    logic            load_en;
    logic            compute_en;
    logic [DW_N-1:0] n_idx;
    logic [DW_K-1:0] k_idx;
    logic            acc_clr;
    logic            out_valid;
    logic [DW_N-1:0] out_col;
    logic            done;
    logic [1:0]      dbg_state;

    // Handshake: start is taken on a rising edge where ready=1 and abort=0, otherwise it is
    // dropped (no queuing). out_valid and done are single-cycle pulses with no back-pressure.
    modport master (
        output start, abort,
        input  ready, busy, load_en, compute_en, n_idx, k_idx, acc_clr,
        input  out_valid, out_col, done, dbg_state
    );

    modport slave (
        input  start, abort,
        output ready, busy, load_en, compute_en, n_idx, k_idx, acc_clr,
        output out_valid, out_col, done, dbg_state
    );
endinterface

// File: rtl/tc_seq_ctrl.sv
// Tile-job sequencer for the tensor-core datapath: LOAD -> COMP (k inner, n outer) -> DRAIN.
// Every output is a flop; column-valid markers travel through a PIPE_LAT-deep shift register.
module tc_seq_ctrl #(
    parameter int ITER_N   = 16,
    parameter int ITER_K   = 2,
    parameter int LOAD_CYC = 2,
    parameter int PIPE_LAT = 2,
    parameter int DW_N     = 4,
    parameter int DW_K     = 1
) (
    input  logic         clk,
    input  logic         reset,
    tc_seq_ctrl_if.slave bus
);
    localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam int PCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LCW-1:0]  LOAD_LAST  = LCW'(LOAD_CYC - 1);
    localparam logic [PCW-1:0]  DRAIN_LAST = PCW'(PIPE_LAT - 1);
    localparam logic [DW_N-1:0] N_LAST     = DW_N'(ITER_N - 1);
    localparam logic [DW_K-1:0] K_LAST     = DW_K'(ITER_K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COMP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LCW-1:0]  r_load_cnt;
    logic [LCW-1:0]  w_load_cnt_nxt;
    logic [PCW-1:0]  r_drain_cnt;
    logic [PCW-1:0]  w_drain_cnt_nxt;
    logic [DW_N-1:0] r_n;
    logic [DW_N-1:0] w_n_nxt;
    logic [DW_K-1:0] r_k;
    logic [DW_K-1:0] w_k_nxt;
    logic            w_push;
    logic            w_flush;

    logic            r_ready;
    logic            r_busy;
    logic            r_load_en;
    logic            r_compute_en;
    logic            r_acc_clr;
    logic            r_done;

    logic            r_pv [PIPE_LAT];
    logic [DW_N-1:0] r_pc [PIPE_LAT];
    logic            w_sv [PIPE_LAT];
    logic [DW_N-1:0] w_sc [PIPE_LAT];

    // Next-state and counter logic; abort from any active state flushes and returns to IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_cnt_nxt  = '0;
        w_drain_cnt_nxt = '0;
        w_n_nxt         = '0;
        w_k_nxt         = '0;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                end else if (r_load_cnt == LOAD_LAST) begin
                    w_state_nxt = S_COMP;
                end else begin
                    w_load_cnt_nxt = r_load_cnt + 1'b1;
                end
            end
            S_COMP: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                end else if (r_k == K_LAST) begin
                    w_push = 1'b1;
                    if (r_n == N_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_n_nxt = r_n + 1'b1;
                    end
                end else begin
                    w_n_nxt = r_n;
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage 0 takes the current push; each later stage takes its predecessor.
    always_comb begin
        w_sv[0] = w_push;
        w_sc[0] = r_n;
        for (int i = 1; i < PIPE_LAT; i++) begin
            w_sv[i] = r_pv[i-1];
            w_sc[i] = r_pc[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_load_cnt   <= '0;
            r_drain_cnt  <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_load_en    <= 1'b0;
            r_compute_en <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_cnt   <= w_load_cnt_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_n          <= w_n_nxt;
            r_k          <= w_k_nxt;
            r_ready      <= (w_state_nxt == S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_load_en    <= (w_state_nxt == S_LOAD);
            r_compute_en <= (w_state_nxt == S_COMP);
            r_acc_clr    <= (w_state_nxt == S_COMP) && (w_k_nxt == '0);
            r_done       <= (w_state_nxt == S_DRAIN) && (w_drain_cnt_nxt == DRAIN_LAST);
        end
    end

    // Column registers load only with valid entries so out_col holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pc[i] <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pv[i] <= w_sv[i];
                if (w_sv[i]) begin
                    r_pc[i] <= w_sc[i];
                end
            end
        end
    end

    assign bus.ready      = r_ready;
    assign bus.busy       = r_busy;
    assign bus.load_en    = r_load_en;
    assign bus.compute_en = r_compute_en;
    assign bus.n_idx      = r_n;
    assign bus.k_idx      = r_k;
    assign bus.acc_clr    = r_acc_clr;
    assign bus.out_valid  = r_pv[PIPE_LAT-1];
    assign bus.out_col    = r_pc[PIPE_LAT-1];
    assign bus.done       = r_done;
    assign bus.dbg_state  = r_state;

endmodule
